// File: rtl/oscill_nios_sw_pkg.sv
// Shared constants for the oscilloscope slide-switch controller:
// Avalon register offsets and the default debounce window.
package oscill_nios_sw_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // 1 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
endpackage

// File: rtl/oscill_nios_sw_debounce.sv
// One switch bit: two-flop synchroniser, hold counter and accepted level.
// toggle is high in the cycle whose closing edge flips stable.
module oscill_nios_sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic stable,
    output logic toggle
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = in_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        toggle   = 1'b0;
        // Any return to the accepted level restarts the hold window.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            toggle   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
endmodule

// File: rtl/oscill_nios_sw_ctrl.sv
// Avalon-MM slave for the debounced slide switches: DATA, IRQMASK and
// write-1-to-clear EDGECAP registers with a maskable level interrupt.
module oscill_nios_sw_ctrl
    import oscill_nios_sw_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] stable, toggle;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_mask, wr_edge;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        oscill_nios_sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .in_raw(in_port[i]),
            .stable(stable[i]),
            .toggle(toggle[i])
        );
    end

    assign wr_mask      = chipselect && !write_n && (address == ADDR_IRQMASK);
    assign wr_edge      = chipselect && !write_n && (address == ADDR_EDGECAP);
    assign unused_wdata = ^writedata;

    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_mask) irqmask_d = writedata[WIDTH-1:0];

        // Clear first, then OR in new edges so a colliding edge survives.
        edgecap_d = edgecap_q;
        if (wr_edge) edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
        edgecap_d = edgecap_d | toggle;

        irq_d = |(edgecap_d & irqmask_d);

        readdata_d = '0;
        unique case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_oscill_nios_sw_ctrl.sv
// Directed bench for oscill_nios_sw_ctrl with a 4-cycle debounce window;
// reads push expectations, a monitor checks readdata/irq after the read edge.
module tb_oscill_nios_sw_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  in_port;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        bit          chk_irq;
        logic        irq;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_issued;

    always #5 clk = ~clk;

    oscill_nios_sw_ctrl #(
        .WIDTH          (10),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // Monitor: a read is presented in the cycle chipselect && write_n is
    // sampled; readdata (and irq) are checked just after that edge.
    always @(posedge clk) begin
        mon_issued = chipselect && write_n && !reset;
        #1;
        if (mon_issued) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read readdata=0x%08h with no expectation", readdata);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (readdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL %s readdata got=0x%08h want=0x%08h", mon_e.name, readdata, mon_e.data);
                end
                if (mon_e.chk_irq) begin
                    checks++;
                    if (irq !== mon_e.irq) begin
                        failures++;
                        $display("FAIL %s irq got=%b want=%b", mon_e.name, irq, mon_e.irq);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic rd(input logic [1:0] a, input logic [31:0] d, input bit ci, input logic ei, input string nm);
        exp_t e;
        e.data = d; e.chk_irq = ci; e.irq = ei; e.name = nm;
        exp_q.push_back(e);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        step(3);
        reset = 1'b0;

        // Reset values
        rd(0, 32'h0, 1, 1'b0, "rst_data");
        rd(1, 32'h0, 1, 1'b0, "rst_mask");
        rd(2, 32'h0, 1, 1'b0, "rst_rsvd");
        rd(3, 32'h0, 1, 1'b0, "rst_edge");

        // Clean edge: stable flips on the 6th edge, visible on a read one later
        in_port[3] = 1'b1;
        step(5);
        rd(0, 32'h0,   0, 1'b0, "edge_data_early");
        rd(0, 32'h008, 0, 1'b0, "edge_data_on_time");
        rd(3, 32'h008, 1, 1'b0, "edge_cap_masked");
        wr(3, 32'h008);
        rd(3, 32'h0,   0, 1'b0, "edge_cap_cleared");

        // Reserved offset ignores writes; mask bits above WIDTH read 0
        wr(2, 32'hFFFF_FFFF);
        rd(2, 32'h0, 0, 1'b0, "rsvd_write_ignored");
        wr(1, 32'hFFFF_FC00);
        rd(1, 32'h0, 0, 1'b0, "mask_upper_bits");

        // Glitch of 3 cycles rejected
        in_port[0] = 1'b1;
        step(3);
        in_port[0] = 1'b0;
        step(8);
        rd(0, 32'h008, 0, 1'b0, "glitch_data");
        rd(3, 32'h0,   0, 1'b0, "glitch_edge");

        // 4-cycle pulse accepted: rises then falls, edge captured
        in_port[0] = 1'b1;
        step(4);
        in_port[0] = 1'b0;
        step(12);
        rd(0, 32'h008, 0, 1'b0, "pulse_data");
        rd(3, 32'h001, 0, 1'b0, "pulse_edge");
        wr(3, 32'h001);

        // Interrupt path
        wr(1, 32'h0000_0201);
        rd(1, 32'h201, 1, 1'b0, "mask_readback");
        in_port[9] = 1'b1;
        step(4);
        rd(3, 32'h0,   1, 1'b0, "irq_before_edge");
        step(1);
        rd(3, 32'h200, 1, 1'b1, "irq_after_edge");
        wr(3, 32'h200);
        rd(3, 32'h0,   1, 1'b0, "irq_cleared");

        // Set-vs-clear collision on bit 2: W1C lands on the toggle cycle
        in_port[2] = 1'b1;
        step(5);
        wr(3, 32'h004);
        rd(3, 32'h004, 1, 1'b0, "collision_set_wins");
        wr(3, 32'h004);
        rd(0, 32'h20C, 0, 1'b0, "collision_data");

        // Reset mid-debounce
        in_port = 10'h3FF;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd(1, 32'h0, 1, 1'b0, "midrst_mask");
        rd(3, 32'h0, 1, 1'b0, "midrst_edge");
        rd(0, 32'h0, 0, 1'b0, "midrst_data");
        step(2);
        rd(0, 32'h0,   0, 1'b0, "midrst_data_early");
        rd(0, 32'h3FF, 0, 1'b0, "midrst_data_on_time");
        rd(3, 32'h3FF, 1, 1'b0, "midrst_edge_all");

        step(4);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
